mops_stim_gen: RTL and testbench

- Synthetic 40 MHz ADC stimulus generator for closed-loop test of the MoPS trigger path.
- Produces up to three ADC streams of programmable staircase pulses (positive steps followed by a decaying tail) on a flat baseline.
- Sits in front of the compatibility trigger block, muxed in place of the real ADC inputs under test control.
- Drives a bin-aligned marker so a bench can predict the exact bin of the expected MoPS trigger.

---
 rtl/mops_stim_if.sv | 29 ++
 rtl/mops_stim_gen.sv | 170 +++++++++++++++++
 tb/tb_mops_stim_gen.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mops_stim_if.sv
// mops_stim_if: control, configuration and sample bus of the MoPS stimulus generator.
interface mops_stim_if #(
    parameter int ADC_WIDTH   = 12,
    parameter int PERIOD_BITS = 16
);
    logic                   START;
    logic                   ABORT;
    logic [ADC_WIDTH-1:0]   BASELINE;
    logic [ADC_WIDTH-1:0]   STEP_AMP;
    logic [3:0]             RISE_BINS;
    logic [2:0]             DECAY_SHIFT;
    logic [PERIOD_BITS-1:0] PERIOD;
    logic [PERIOD_BITS-1:0] N_PULSES;
    logic [2:0]             PMT_MASK;
    logic [ADC_WIDTH-1:0]   ADC0;
    logic [ADC_WIDTH-1:0]   ADC1;
    logic [ADC_WIDTH-1:0]   ADC2;
    logic                   BUSY;
    logic                   DONE;
    logic                   PULSE_MARK;
    modport master (
        output START, ABORT, BASELINE, STEP_AMP, RISE_BINS, DECAY_SHIFT, PERIOD, N_PULSES, PMT_MASK,
        input  ADC0, ADC1, ADC2, BUSY, DONE, PULSE_MARK
    );
    modport slave (
        input  START, ABORT, BASELINE, STEP_AMP, RISE_BINS, DECAY_SHIFT, PERIOD, N_PULSES, PMT_MASK,
        output ADC0, ADC1, ADC2, BUSY, DONE, PULSE_MARK
    );
endinterface

// File: rtl/mops_stim_gen.sv
// mops_stim_gen: synthetic 40 MHz staircase-pulse ADC stimulus for closed-loop MoPS trigger tests.
// Define MOPS_STIM_JITTER_EN to add LFSR-driven 0..7 extra bins to each pulse's period.
module mops_stim_gen #(
    parameter int ADC_WIDTH   = 12,
    parameter int PERIOD_BITS = 16
) (
    input logic        CLK120,
    input logic        RESET,
    input logic [1:0]  ENABLE40,
    mops_stim_if.slave bus
);
    localparam int W  = ADC_WIDTH;
    localparam int KW = PERIOD_BITS + 1;
    typedef enum logic [2:0] {IDLE, ARM, RISE, DECAY, FINISH} state_t;
    state_t state_q, state_d;
    logic [W-1:0] b_q, b_d, s_q, s_d, v_q, v_d;
    logic [W-1:0] adc_q [3];
    logic [W-1:0] adc_d [3];
    logic [3:0] r_q, r_d;
    logic [2:0] ds_q, ds_d, m_q, m_d, jit;
    logic [PERIOD_BITS-1:0] p_q, p_d, n_q, n_d, pc_q, pc_d, pc_n;
    logic [KW-1:0] k_q, k_d, rp1, peff;
    logic busy_q, busy_d, done_q, done_d, mark_q, mark_d, abort_q, abort_d;
    logic tick, last_bin, rising, finish;
    logic [W:0] sum_b, sum_v;
    logic [W-1:0] rise_b, rise_v, diff, dv, dec;
`ifdef MOPS_STIM_JITTER_EN
    logic [15:0] lfsr_q, lfsr_d, lfsr_n;
    logic [2:0] jit_q, jit_d;
    assign jit = jit_q;
    assign lfsr_n = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`else
    assign jit = 3'd0;
`endif
    assign tick = ENABLE40 == 2'd0;
    assign sum_b = {1'b0, b_q} + {1'b0, s_q};
    assign sum_v = {1'b0, v_q} + {1'b0, s_q};
    assign rise_b = sum_b[W] ? '1 : sum_b[W-1:0];
    assign rise_v = sum_v[W] ? '1 : sum_v[W-1:0];
    // a nonzero tail always shrinks by at least one LSB so it reaches baseline
    assign diff = v_q - b_q;
    assign dv = diff >> ds_q;
    assign dec = v_q - ((dv == '0 && diff != '0) ? W'(1) : dv);
    assign rp1 = KW'(r_q) + KW'(1);
    assign peff = ((KW'(p_q) > rp1) ? KW'(p_q) : rp1) + KW'(jit);
    assign last_bin = k_q == peff - KW'(1);
    assign rising = k_q + KW'(1) < KW'(r_q);
    assign pc_n = pc_q + PERIOD_BITS'(1);
    assign finish = abort_q | bus.ABORT | (state_q != ARM && last_bin && n_q != '0 && pc_n == n_q);
    always_comb begin
        state_d = state_q;
        b_d = b_q;
        s_d = s_q;
        r_d = r_q;
        ds_d = ds_q;
        p_d = p_q;
        n_d = n_q;
        m_d = m_q;
        v_d = v_q;
        k_d = k_q;
        pc_d = pc_q;
        busy_d = busy_q;
        done_d = 1'b0;
        mark_d = mark_q & ~tick;
        abort_d = abort_q | (bus.ABORT & (state_q != IDLE));
`ifdef MOPS_STIM_JITTER_EN
        lfsr_d = lfsr_q;
        jit_d = jit_q;
`endif
        case (state_q)
            IDLE: if (bus.START) begin
                b_d = bus.BASELINE;
                s_d = bus.STEP_AMP;
                r_d = (bus.RISE_BINS == 4'd0) ? 4'd1 : bus.RISE_BINS;
                ds_d = bus.DECAY_SHIFT;
                p_d = bus.PERIOD;
                n_d = bus.N_PULSES;
                m_d = bus.PMT_MASK;
                pc_d = '0;
                busy_d = 1'b1;
                abort_d = 1'b0;
                state_d = ARM;
`ifdef MOPS_STIM_JITTER_EN
                lfsr_d = 16'hACE1;
`endif
            end
            FINISH: begin
                state_d = IDLE;
                abort_d = 1'b0;
            end
            default: if (tick) begin
                if (finish) begin
                    state_d = FINISH;
                    v_d = b_q;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    mark_d = 1'b0;
                    abort_d = 1'b0;
                end else if (state_q == ARM || last_bin) begin
                    state_d = RISE;
                    v_d = rise_b;
                    k_d = '0;
                    mark_d = 1'b1;
                    pc_d = (state_q == ARM) ? pc_q : pc_n;
`ifdef MOPS_STIM_JITTER_EN
                    lfsr_d = lfsr_n;
                    jit_d = lfsr_n[2:0];
`endif
                end else begin
                    state_d = rising ? RISE : DECAY;
                    v_d = rising ? rise_v : dec;
                    k_d = k_q + KW'(1);
                end
            end
        endcase
        for (int i = 0; i < 3; i++)
            adc_d[i] = (tick && state_q inside {ARM, RISE, DECAY}) ? (m_q[i] ? v_d : b_q) : adc_q[i];
    end
    always_ff @(posedge CLK120) begin
        if (RESET) begin
            state_q <= IDLE;
            b_q <= '0;
            s_q <= '0;
            r_q <= '0;
            ds_q <= '0;
            p_q <= '0;
            n_q <= '0;
            m_q <= '0;
            v_q <= '0;
            k_q <= '0;
            pc_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mark_q <= 1'b0;
            abort_q <= 1'b0;
            adc_q <= '{default: '0};
`ifdef MOPS_STIM_JITTER_EN
            lfsr_q <= 16'hACE1;
            jit_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            b_q <= b_d;
            s_q <= s_d;
            r_q <= r_d;
            ds_q <= ds_d;
            p_q <= p_d;
            n_q <= n_d;
            m_q <= m_d;
            v_q <= v_d;
            k_q <= k_d;
            pc_q <= pc_d;
            busy_q <= busy_d;
            done_q <= done_d;
            mark_q <= mark_d;
            abort_q <= abort_d;
            adc_q <= adc_d;
`ifdef MOPS_STIM_JITTER_EN
            lfsr_q <= lfsr_d;
            jit_q <= jit_d;
`endif
        end
    end
    assign bus.ADC0 = adc_q[0];
    assign bus.ADC1 = adc_q[1];
    assign bus.ADC2 = adc_q[2];
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.PULSE_MARK = mark_q;
endmodule

// File: tb/tb_mops_stim_gen.sv
// tb_mops_stim_gen: random and directed runs of mops_stim_gen checked every cycle against a
// per-pulse waveform plan computed from the generator's rules.
`timescale 1ns/1ps
module tb_mops_stim_gen;
    localparam int W = 12;
    localparam int PB = 16;
    localparam int MAXV = (1 << W) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] en = 2'd0;
    int checks = 0;
    int errors = 0;
    int lit1[10] = '{270, 290, 310, 295, 284, 276, 270, 265, 262, 259};
    int plan_v[$];
    bit plan_m[$];
    int m_adc[3];
    int m_b, m_mask, pi;
    int m_mode = 0;
    bit m_busy, m_done, m_mark, m_abort;
    mops_stim_if #(.ADC_WIDTH(W), .PERIOD_BITS(PB)) bus();
    mops_stim_gen #(.ADC_WIDTH(W), .PERIOD_BITS(PB)) dut (
        .CLK120(clk), .RESET(rst), .ENABLE40(en), .bus(bus)
    );
    always #5 clk = ~clk;
    initial forever begin
        @(negedge clk);
        en = (en == 2'd2) ? 2'd0 : en + 2'd1;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction
    function automatic logic [15:0] lfsr_step(logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction
    // Expected per-bin output of the whole run; endless runs get a long plan that ABORT cuts short.
    function automatic void build_plan(int b, int s, int r, int ds, int p, int n);
        int re = (r == 0) ? 1 : r;
        int pe, v, d;
        logic [15:0] l = 16'hACE1;
        plan_v.delete();
        plan_m.delete();
        for (int j = 0; (n != 0) ? (j < n) : (plan_v.size() < 3000); j++) begin
            pe = (p > re + 1) ? p : re + 1;
`ifdef MOPS_STIM_JITTER_EN
            l = lfsr_step(l);
            pe += int'(l[2:0]);
`endif
            v = b;
            for (int k = 0; k < pe; k++) begin
                if (k < re) v = (b + (k + 1) * s > MAXV) ? MAXV : b + (k + 1) * s;
                else begin
                    d = (v - b) >> ds;
                    if (d == 0 && v > b) d = 1;
                    v -= d;
                end
                plan_v.push_back(v);
                plan_m.push_back(k == 0);
            end
        end
    endfunction
    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_mode = 0;
            m_busy = 1'b0;
            m_mark = 1'b0;
            m_abort = 1'b0;
            m_b = 0;
            for (int i = 0; i < 3; i++) m_adc[i] = 0;
        end else if (m_mode == 0) begin
            if (bus.START) begin
                m_b = int'(bus.BASELINE);
                m_mask = int'(bus.PMT_MASK);
                build_plan(int'(bus.BASELINE), int'(bus.STEP_AMP), int'(bus.RISE_BINS),
                           int'(bus.DECAY_SHIFT), int'(bus.PERIOD), int'(bus.N_PULSES));
                pi = 0;
                m_busy = 1'b1;
                m_abort = 1'b0;
                m_mode = 1;
            end
        end else if (m_mode == 2) m_mode = 0;
        else begin
            m_abort |= bus.ABORT;
            if (en == 2'd0) begin
                if (m_abort || pi >= plan_v.size()) begin
                    for (int i = 0; i < 3; i++) m_adc[i] = m_b;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    m_mark = 1'b0;
                    m_mode = 2;
                end else begin
                    for (int i = 0; i < 3; i++) m_adc[i] = m_mask[i] ? plan_v[pi] : m_b;
                    m_mark = plan_m[pi];
                    pi++;
                end
            end
        end
    end
    always @(posedge clk) begin
        #1;
        chk("ADC0", bus.ADC0, m_adc[0]);
        chk("ADC1", bus.ADC1, m_adc[1]);
        chk("ADC2", bus.ADC2, m_adc[2]);
        chk("BUSY", bus.BUSY, m_busy);
        chk("DONE", bus.DONE, m_done);
        chk("PULSE_MARK", bus.PULSE_MARK, m_mark);
    end
    task automatic wait_tick();
        do @(posedge clk); while (en != 2'd0);
        #1;
    endtask
    task automatic start_run(int b, int s, int r, int ds, int p, int n, int mk, bit ab);
        repeat (2) @(negedge clk);
        bus.BASELINE = W'(b);
        bus.STEP_AMP = W'(s);
        bus.RISE_BINS = 4'(r);
        bus.DECAY_SHIFT = 3'(ds);
        bus.PERIOD = PB'(p);
        bus.N_PULSES = PB'(n);
        bus.PMT_MASK = 3'(mk);
        bus.START = 1'b1;
        bus.ABORT = ab;
        @(negedge clk);
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        chk("busy_after_start", bus.BUSY, 1);
        bus.BASELINE = W'($urandom);
        bus.STEP_AMP = W'($urandom);
        bus.PERIOD = PB'($urandom_range(0, 3));
    endtask
    task automatic wait_done(int lim);
        int c = 0;
        while (bus.DONE !== 1'b1 && c < lim) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("done_seen", bus.DONE, 1);
    endtask
    task automatic pulse_abort();
        @(negedge clk);
        bus.ABORT = 1'b1;
        @(negedge clk);
        bus.ABORT = 1'b0;
    endtask
    initial begin
        int n, dn;
        int got[6];
        bus.START = 0; bus.ABORT = 0; bus.BASELINE = 0; bus.STEP_AMP = 0; bus.RISE_BINS = 0;
        bus.DECAY_SHIFT = 0; bus.PERIOD = 0; bus.N_PULSES = 0; bus.PMT_MASK = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_adc0", bus.ADC0, 0);
        chk("reset_busy", bus.BUSY, 0);
        chk("reset_mark", bus.PULSE_MARK, 0);
        @(negedge clk);
        rst = 1'b0;
        // staircase with decaying tail, two pulses
        start_run(250, 20, 3, 2, 10, 2, 7, 0);
        for (int k = 0; k < 10; k++) begin
            wait_tick();
            chk("t1_bin", bus.ADC0, lit1[k]);
            chk("t1_mark", bus.PULSE_MARK, k == 0);
        end
        n = 0;
        while (bus.DONE !== 1'b1 && n < 15) begin
            wait_tick();
            n++;
            if (n == 1) chk("t1_mark2", bus.PULSE_MARK, 1);
        end
        chk("t1_done_tick", n, 11);
        // saturation, plus a START while busy that must be ignored
        start_run(1000, 2000, 3, 2, 10, 1, 7, 0);
        wait_tick(); chk("sat0", bus.ADC0, 3000);
        wait_tick(); chk("sat1", bus.ADC0, 4095);
        wait_tick(); chk("sat2", bus.ADC0, 4095);
        wait_tick(); chk("sat_decay", bus.ADC0, 3322);
        @(negedge clk); bus.START = 1'b1;
        @(negedge clk); bus.START = 1'b0;
        wait_done(200);
        // PERIOD shorter than the rise: stretched to RISE_BINS+1
        start_run(100, 50, 4, 1, 2, 1, 7, 0);
        for (int k = 0; k < 6; k++) begin
            wait_tick();
            got[k] = int'(bus.ADC0);
            if (k == 5) chk("t3_done", bus.DONE, 1);
        end
        chk("t3_r3", got[3], 300);
        chk("t3_decay", got[4], 200);
        chk("t3_fin", got[5], 100);
        // ABORT while idle is ignored
        pulse_abort();
        repeat (3) @(posedge clk);
        #1;
        chk("idle_abort_busy", bus.BUSY, 0);
        // endless run aborted in the 37th bin
        start_run(500, 100, 2, 3, 7, 0, 7, 0);
        repeat (37) wait_tick();
        pulse_abort();
        wait_tick();
        chk("abort_adc", bus.ADC0, 500);
        chk("abort_done", bus.DONE, 1);
        chk("abort_busy", bus.BUSY, 0);
        dn = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            dn += int'(bus.DONE);
        end
        chk("abort_done_once", dn, 0);
        // masking, with an ABORT coinciding with the START
        start_run(300, 40, 2, 1, 5, 3, 2, 1);
        wait_tick();
        chk("mask_adc0", bus.ADC0, 300);
        chk("mask_adc1", bus.ADC1, 340);
        chk("mask_adc2", bus.ADC2, 300);
        wait_done(300);
        for (int it = 0; it < 12; it++) begin
            bit ab = (it % 3 == 2);
            start_run($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 15),
                      $urandom_range(0, 7), $urandom_range(0, 24), ab ? 0 : $urandom_range(1, 3),
                      $urandom_range(0, 7), 0);
            if (ab) begin
                repeat ($urandom_range(0, 60)) @(negedge clk);
                pulse_abort();
            end
            wait_done(700);
        end
        // RESET mid-run: back to reset state, no DONE
        start_run(700, 30, 5, 1, 12, 0, 5, 0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_adc", bus.ADC2, 0);
        start_run(200, 60, 3, 2, 10, 8, 7, 0);
        wait_done(1500);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
